pipe_skid_reg: RTL and testbench
================================

PIPE_SKID_REG -- requirements
Module: pipe_skid_reg

Interface
REQ-001 The block SHALL have parameter DATA_W, default 64, meaning the payload width in bits.
REQ-002 The block SHALL have parameter BUBBLE_VAL, default {(DATA_W-16) zeros, INST_FLUSHED}, meaning the payload driven whenever no valid entry is presented.
REQ-003 The block SHALL have parameter CNT_W, default 16, meaning the stall-counter width in bits.
REQ-004 The block SHALL have port clk, input, 1 bit: clock, rising-edge.
REQ-005 The block SHALL have port reset_n, input, 1 bit: reset, synchronous, active-low.
REQ-006 The block SHALL have port flush, input, 1 bit: discard all held entries.
REQ-007 The block SHALL have port in_valid, input, 1 bit: upstream payload valid.
REQ-008 The block SHALL have port in_ready, output, 1 bit: block can accept.
REQ-009 The block SHALL have port in_data, input, DATA_W bits: upstream payload.
REQ-010 The block SHALL have port out_valid, output, 1 bit: downstream payload valid.
REQ-011 The block SHALL have port out_ready, input, 1 bit: downstream accepts.
REQ-012 The block SHALL have port out_data, output, DATA_W bits: downstream payload.
REQ-013 The block SHALL have port occupancy, output, 2 bits: held entries, 0 to 2.
REQ-014 The block SHALL have port stall_cnt, output, CNT_W bits: saturating count of cycles with out_valid=1 and out_ready=0.

Function
REQ-015 The block SHALL hold two entries, main and skid, each a valid bit plus a payload.
REQ-016 The block SHALL run a state machine with states EMPTY (occupancy 0), ONE (occupancy 1, main valid) and FULL (occupancy 2, main and skid valid).
REQ-017 A transfer in SHALL occur when in_valid=1 and in_ready=1; a transfer out SHALL occur when out_valid=1 and out_ready=1.
REQ-018 in_ready SHALL be driven from a register: 1 in EMPTY and ONE, 0 in FULL, with no combinational path from out_ready.
REQ-019 out_valid SHALL equal the main valid bit.
REQ-020 out_data SHALL equal the main payload when out_valid=1, and BUBBLE_VAL otherwise.
REQ-021 Latency: data accepted in cycle N SHALL appear on out_data in cycle N+1 when the block was empty.
REQ-022 Throughput: the block SHALL sustain one transfer per cycle when out_ready is held at 1.
REQ-023 EMPTY with a transfer in SHALL go to ONE, loading main.
REQ-024 ONE with a transfer in and a transfer out SHALL stay in ONE, replacing main.
REQ-025 ONE with a transfer in and no transfer out SHALL go to FULL, loading skid.
REQ-026 ONE with a transfer out and no transfer in SHALL go to EMPTY.
REQ-027 FULL with a transfer out SHALL go to ONE, moving skid into main (in_ready is 0, so no transfer in occurs).
REQ-028 Entries SHALL leave in order of arrival, with no loss and no duplication.
REQ-029 flush=1 SHALL clear both valid bits and both payloads to BUBBLE_VAL at the next edge, go to EMPTY and set in_ready=1 the following cycle.
REQ-030 Flush boundary: a transfer in or out in a flush cycle SHALL have its payload discarded; out_valid in that cycle still reflects pre-flush state.
REQ-031 stall_cnt SHALL increment by 1 in each cycle with out_valid=1 and out_ready=0.
REQ-032 stall_cnt SHALL saturate at 2^CNT_W-1, never wrap, and be unaffected by flush.
REQ-033 Inputs SHALL be ignored, and in_valid may fall, without affecting held entries.

Reset
REQ-034 With reset_n=0 at an edge, the block SHALL enter EMPTY with out_valid=0, out_data=BUBBLE_VAL, in_ready=1, occupancy=0 and stall_cnt=0.
REQ-035 Reset SHALL take priority over flush and over all transfers, including when asserted mid-operation in FULL.

Structure
REQ-036 WORD_SIZE, INST_FLUSHED, inst_type_bitlen and the state encoding SHALL live in the shared package cpu_pipe_pkg.
REQ-037 The block SHALL be a single module with no sub-module, instanced once per IF/ID, ID/EX, EX/MEM and MEM/WB boundary with DATA_W set to the concatenated field width.

Verification
REQ-038 Scenario: reset, then in_data=0x1234 valid for 1 cycle with out_ready=1 -> out_valid=1 and out_data=0x1234 exactly one cycle later, then out_valid=0 with out_data=BUBBLE_VAL.
REQ-039 Scenario: out_ready=0, push A=0x11, B=0x22 -> occupancy=2 and in_ready=0; release out_ready -> A then B delivered on consecutive cycles.
REQ-040 Scenario: streaming 100 incrementing words with out_ready=1 -> 100 outputs in order with no gaps after the first.
REQ-041 Scenario: FULL, then flush with in_valid=1 and in_data=0x33 -> next cycle occupancy=0, out_valid=0, in_ready=1, and 0x33 is never output.
REQ-042 Scenario: CNT_W=4, hold out_valid=1 and out_ready=0 for 20 cycles -> stall_cnt=15, and stall_cnt stays 15 after a flush.
REQ-043 Scenario: reset_n=0 asserted in FULL with flush=1 -> reset values of REQ-034 at the next edge.

Source files
------------

// File: rtl/cpu_pipe_pkg.sv
// rtl/cpu_pipe_pkg.sv - shared pipeline constants and skid register state encoding
package cpu_pipe_pkg;

  localparam int WORD_SIZE        = 32;
  localparam int inst_type_bitlen = 16;

  // Marker payload carried by a stage register that holds no instruction.
  localparam logic [inst_type_bitlen-1:0] INST_FLUSHED = 16'hF1A5;

  // Encoding equals the number of held entries, so occupancy is the state itself.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } skid_state_t;

endpackage

// File: rtl/pipe_skid_reg.sv
// rtl/pipe_skid_reg.sv - two-entry skid pipeline register with flush and stall counter
module pipe_skid_reg
  import cpu_pipe_pkg::*;
#(
  parameter int                DATA_W     = 64,
  parameter logic [DATA_W-1:0] BUBBLE_VAL = DATA_W'(INST_FLUSHED),
  parameter int                CNT_W      = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  stall_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  skid_state_t       state;
  logic              main_valid;
  logic              skid_valid;
  logic [DATA_W-1:0] main_data;
  logic [DATA_W-1:0] skid_data;
  logic              in_ready_q;
  logic [CNT_W-1:0]  stall_cnt_q;

  logic push;
  logic pop;

  assign push = in_valid && in_ready_q;
  assign pop  = main_valid && out_ready;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state       <= ST_EMPTY;
      main_valid  <= 1'b0;
      skid_valid  <= 1'b0;
      main_data   <= BUBBLE_VAL;
      skid_data   <= BUBBLE_VAL;
      in_ready_q  <= 1'b1;
      stall_cnt_q <= '0;
    end else begin
      // Stalls are counted against pre-flush state and survive a flush.
      if (main_valid && !out_ready && stall_cnt_q != CNT_MAX)
        stall_cnt_q <= stall_cnt_q + CNT_W'(1);

      if (flush) begin
        state      <= ST_EMPTY;
        main_valid <= 1'b0;
        skid_valid <= 1'b0;
        main_data  <= BUBBLE_VAL;
        skid_data  <= BUBBLE_VAL;
        in_ready_q <= 1'b1;
      end else begin
        case (state)
          ST_EMPTY: begin
            if (push) begin
              state      <= ST_ONE;
              main_valid <= 1'b1;
              main_data  <= in_data;
            end
          end
          ST_ONE: begin
            if (push && pop) begin
              main_data <= in_data;
            end else if (push) begin
              state      <= ST_FULL;
              skid_valid <= 1'b1;
              skid_data  <= in_data;
              in_ready_q <= 1'b0;
            end else if (pop) begin
              state      <= ST_EMPTY;
              main_valid <= 1'b0;
              main_data  <= BUBBLE_VAL;
            end
          end
          ST_FULL: begin
            // in_ready is low here, so only a drain can happen.
            if (pop) begin
              state      <= ST_ONE;
              main_data  <= skid_data;
              skid_valid <= 1'b0;
              skid_data  <= BUBBLE_VAL;
              in_ready_q <= 1'b1;
            end
          end
          default: begin
            state      <= ST_EMPTY;
            main_valid <= 1'b0;
            skid_valid <= 1'b0;
            in_ready_q <= 1'b1;
          end
        endcase
      end
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = main_valid;
  assign out_data  = main_valid ? main_data : BUBBLE_VAL;
  assign occupancy = state;
  assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_pipe_skid_reg.sv
// tb/tb_pipe_skid_reg.sv - self-checking bench for pipe_skid_reg
module tb_pipe_skid_reg;
  import cpu_pipe_pkg::*;

  localparam int DW = 32;
  localparam int CW = 4;
  localparam logic [DW-1:0] BUB = DW'(INST_FLUSHED);
  localparam int CMAX = (1 << CW) - 1;

  logic          clk;
  logic          reset_n;
  logic          flush;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic [1:0]    occupancy;
  logic [CW-1:0] stall_cnt;

  pipe_skid_reg #(.DATA_W(DW), .CNT_W(CW)) dut (
    .clk(clk), .reset_n(reset_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .occupancy(occupancy), .stall_cnt(stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference: an in-order queue of capacity two plus a saturating counter.
  logic [DW-1:0] mq[$];
  int            mcnt = 0;

  typedef struct {
    logic          rst_n;
    logic          fl;
    logic          iv;
    logic [DW-1:0] d;
    logic          ordy;
    logic          ev;
    logic [DW-1:0] ed;
    logic          erdy;
    logic [1:0]    eocc;
  } vec_t;

  vec_t tbl[12];
  logic [DW-1:0] got[$];
  int first_i, last_i;

  task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_step();
    bit ov, ir;
    if (!reset_n) begin
      mq.delete();
      mcnt = 0;
    end else begin
      ov = (mq.size() > 0);
      ir = (mq.size() < 2);
      if (ov && !out_ready && mcnt < CMAX) mcnt++;
      if (flush) mq.delete();
      else begin
        if (ov && out_ready) void'(mq.pop_front());
        if (in_valid && ir) mq.push_back(in_data);
      end
    end
  endfunction

  task automatic check_model(input string tag);
    cmp({tag, ".out_valid"}, 64'(out_valid), 64'(mq.size() > 0));
    cmp({tag, ".out_data"},  64'(out_data),  64'((mq.size() > 0) ? mq[0] : BUB));
    cmp({tag, ".in_ready"},  64'(in_ready),  64'(mq.size() < 2));
    cmp({tag, ".occupancy"}, 64'(occupancy), 64'(mq.size()));
    cmp({tag, ".stall_cnt"}, 64'(stall_cnt), 64'(mcnt));
  endtask

  task automatic tick(input string tag);
    model_step();
    @(posedge clk);
    #1;
    check_model(tag);
  endtask

  task automatic drive(input logic r, input logic f, input logic iv, input logic [DW-1:0] d, input logic o);
    reset_n = r; flush = f; in_valid = iv; in_data = d; out_ready = o;
  endtask

  initial begin
    drive(1'b0, 1'b0, 1'b0, '0, 1'b0);

    //          rst fl iv data      ordy  ev  edata     erdy eocc
    tbl[0]  = '{1'b0, 1'b0, 1'b0, 32'h0,    1'b1, 1'b0, BUB,      1'b1, 2'd0};
    tbl[1]  = '{1'b1, 1'b0, 1'b1, 32'h1234, 1'b1, 1'b1, 32'h1234, 1'b1, 2'd1};
    tbl[2]  = '{1'b1, 1'b0, 1'b0, 32'h0,    1'b1, 1'b0, BUB,      1'b1, 2'd0};
    tbl[3]  = '{1'b1, 1'b0, 1'b1, 32'h11,   1'b0, 1'b1, 32'h11,   1'b1, 2'd1};
    tbl[4]  = '{1'b1, 1'b0, 1'b1, 32'h22,   1'b0, 1'b1, 32'h11,   1'b0, 2'd2};
    tbl[5]  = '{1'b1, 1'b0, 1'b1, 32'h99,   1'b0, 1'b1, 32'h11,   1'b0, 2'd2};
    tbl[6]  = '{1'b1, 1'b0, 1'b0, 32'h0,    1'b1, 1'b1, 32'h22,   1'b1, 2'd1};
    tbl[7]  = '{1'b1, 1'b0, 1'b0, 32'h0,    1'b1, 1'b0, BUB,      1'b1, 2'd0};
    tbl[8]  = '{1'b1, 1'b0, 1'b1, 32'h55,   1'b0, 1'b1, 32'h55,   1'b1, 2'd1};
    tbl[9]  = '{1'b1, 1'b0, 1'b1, 32'h66,   1'b0, 1'b1, 32'h55,   1'b0, 2'd2};
    tbl[10] = '{1'b1, 1'b1, 1'b1, 32'h33,   1'b1, 1'b0, BUB,      1'b1, 2'd0};
    tbl[11] = '{1'b1, 1'b0, 1'b0, 32'h0,    1'b1, 1'b0, BUB,      1'b1, 2'd0};

    @(negedge clk);
    for (int i = 0; i < 12; i++) begin
      drive(tbl[i].rst_n, tbl[i].fl, tbl[i].iv, tbl[i].d, tbl[i].ordy);
      tick($sformatf("tbl%0d", i));
      cmp($sformatf("tbl%0d.v", i),    64'(out_valid), 64'(tbl[i].ev));
      cmp($sformatf("tbl%0d.d", i),    64'(out_data),  64'(tbl[i].ed));
      cmp($sformatf("tbl%0d.rdy", i),  64'(in_ready),  64'(tbl[i].erdy));
      cmp($sformatf("tbl%0d.occ", i),  64'(occupancy), 64'(tbl[i].eocc));
    end

    // Streaming: 100 words with out_ready held high.
    first_i = -1; last_i = -1;
    for (int i = 0; i < 104; i++) begin
      drive(1'b1, 1'b0, i < 100, DW'(1000 + i), 1'b1);
      tick("stream");
      if (out_valid) begin
        got.push_back(out_data);
        if (first_i < 0) first_i = i;
        last_i = i;
      end
    end
    cmp("stream.count", 64'(got.size()), 64'd100);
    cmp("stream.span", 64'(last_i - first_i), 64'd99);
    for (int i = 0; i < got.size(); i++)
      if (got[i] !== DW'(1000 + i)) cmp($sformatf("stream.word%0d", i), 64'(got[i]), 64'(1000 + i));

    // Stall counter saturation and flush immunity.
    drive(1'b0, 1'b0, 1'b0, '0, 1'b0); tick("sat.rst");
    drive(1'b1, 1'b0, 1'b1, 32'hAB, 1'b0); tick("sat.push");
    drive(1'b1, 1'b0, 1'b0, '0, 1'b0);
    for (int i = 0; i < 20; i++) tick("sat.hold");
    cmp("sat.cnt", 64'(stall_cnt), 64'd15);
    drive(1'b1, 1'b1, 1'b0, '0, 1'b0); tick("sat.flush");
    cmp("sat.cnt_after_flush", 64'(stall_cnt), 64'd15);
    cmp("sat.occ_after_flush", 64'(occupancy), 64'd0);

    // Reset while FULL and flushing.
    drive(1'b1, 1'b0, 1'b1, 32'hA1, 1'b0); tick("rf.a");
    drive(1'b1, 1'b0, 1'b1, 32'hA2, 1'b0); tick("rf.b");
    cmp("rf.full", 64'(occupancy), 64'd2);
    drive(1'b0, 1'b1, 1'b1, 32'hA3, 1'b1); tick("rf.rst");
    cmp("rf.v",   64'(out_valid), 64'd0);
    cmp("rf.d",   64'(out_data),  64'(BUB));
    cmp("rf.rdy", 64'(in_ready),  64'd1);
    cmp("rf.occ", 64'(occupancy), 64'd0);
    cmp("rf.cnt", 64'(stall_cnt), 64'd0);

    // Randomized traffic against the queue model.
    for (int i = 0; i < 600; i++) begin
      drive($urandom_range(0, 99) != 0, $urandom_range(0, 24) == 0,
            $urandom_range(0, 2) != 0, DW'($urandom), $urandom_range(0, 3) != 0);
      tick("rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
